mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised load/store access unit between the core's memory stage and the data-memory bus. It takes one load or store request at a time, converts byte-granular accesses into aligned bus beats with byte enables, and sign- or zero-extends returned load data. Accesses that cross a bus word can be split into two beats. It replaces the purely combinational result extender with a handshaked, width-generic, multi-beat unit.

## Interface
- XLEN, 32: data and bus width in bits; 32 or 64.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  000 none, 001 b, 010 h, 011 w, 100 bu, 101 hu, 110 wu, 111 d. 110 and 111 are legal only for XLEN=64. Stores use 001/010/011/111.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  XLEN  extended load data; 0 for stores, none, and faults.
- resp_fault  out  1  valid with resp_valid; illegal ctrl or disallowed misalignment.
- bus_valid  out  1  bus beat request.
- bus_ready  in  1  beat accepted; for reads, bus_rdata is valid in the same cycle.
- bus_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are 0.
- bus_we  out  1  beat is a write.
- bus_be  out  XLEN/8  byte enables.
- bus_wdata  out  XLEN  lane-shifted store data.
- bus_rdata  in  XLEN  read data.

## Operation
- States:
  - IDLE: req_ready=1. On req_valid, register the request, compute offset = addr mod (XLEN/8) and access size, then go to:
    - RESP with fault, if ctrl is illegal;
    - RESP without fault, if ctrl is 000;
    - BEAT0 otherwise.
  - BEAT0: bus_valid=1, bus_addr = addr with low bits cleared. Byte enables cover lanes offset .. min(offset+size, XLEN/8)-1. On bus_ready, capture the read lanes, then go to BEAT1 if the access crosses the word, else RESP.
  - BEAT1: bus_addr = BEAT0 address + XLEN/8, wrapping modulo 2^ADDR_W. Byte enables cover the remaining low lanes. On bus_ready, go to RESP.
  - RESP: resp_valid=1 for one cycle, then go to IDLE.
- Store data: rotated left by offset*8. The BEAT1 lanes carry the bytes that did not fit in BEAT0.
- Load data: beat lanes are merged, shifted right by offset*8, truncated to the access size, then extended. The b/h/w/d codes sign-extend; the bu/hu/wu codes zero-extend.
- The bus_* signals stay stable while bus_valid=1 and bus_ready=0.
- Reset values: state IDLE; req_ready=1 (combinational from IDLE); resp_valid=0, resp_rdata=0, resp_fault=0; bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
- Reset mid-operation: the unit returns to IDLE immediately, bus_valid drops asynchronously, and the captured data is discarded. No response is issued.

## Timing
- Request accepted in cycle N.
- Aligned access: BEAT0 is in N+1. If bus_ready=1 in N+1, resp_valid is high in N+2.
- Split access: BEAT1 is in N+2 at the earliest; resp_valid in N+3.
- Fault or none: resp_valid in N+1; no bus activity.
- Each cycle of bus_ready=0 adds one cycle of latency.
- Back-to-back throughput: one request per 3 cycles (aligned, zero wait).
- resp_rdata and resp_fault are registered and valid only while resp_valid=1.

## Configuration
- MEM_MISALIGNED_SPLIT_EN defined: word-crossing accesses are split into two beats as described above.
- MEM_MISALIGNED_SPLIT_EN undefined:
  - Any access with offset not a multiple of its size returns resp_fault=1 in N+1, with no bus beat.
  - The BEAT1 state and the merge logic are removed.

## Structure
- Package mem_pkg holds:
  - ctrl encoding localparams (CTRL_NONE … CTRL_D);
  - the state enum (IDLE, BEAT0, BEAT1, RESP);
  - a function mapping ctrl to size in bytes.
- Sub-module mem_lane_extender (parameter XLEN) performs the combinational shift, size truncation and sign/zero extension of merged read data.

## Test plan
- XLEN=32, lb at 0x1003, bus_rdata=0x80xxxxxx → BEAT0 bus_addr 0x1000, bus_be 1000; resp_rdata 0xFFFFFF80 in N+2.
- XLEN=32, lhu at 0x1002, bus_rdata=0xBEEF0000 → bus_be 1100; resp_rdata 0x0000BEEF.
- XLEN=32, sw 0x11223344 at 0x1003 (macro defined):
  - BEAT0: addr 0x1000, be 1000, wdata 0x44xxxxxx;
  - BEAT1: addr 0x1004, be 0111, wdata 0xxx112233;
  - resp in N+3.
- Same sw with macro undefined → resp_fault=1 in N+1; bus_valid never high.
- XLEN=32, ctrl 111 → fault in N+1. XLEN=64, ld at 0x8 with bus_rdata 0x8000000000000001 → resp_rdata equal to it.
- lw with bus_ready held low 3 cycles, then rst asserted during BEAT0 → bus_valid drops, no resp_valid, next req_ready=1.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store access unit.
//   - req_ctrl encodings (CTRL_NONE .. CTRL_D)
//   - state_t: access FSM states (IDLE, BEAT0, BEAT1, RESP)
//   - ctrl_size():   access size in bytes for a ctrl code (0 for none)
//   - ctrl_signed(): 1 when the load result is sign-extended
package mem_pkg;

  localparam logic [2:0] CTRL_NONE = 3'b000;
  localparam logic [2:0] CTRL_B    = 3'b001;
  localparam logic [2:0] CTRL_H    = 3'b010;
  localparam logic [2:0] CTRL_W    = 3'b011;
  localparam logic [2:0] CTRL_BU   = 3'b100;
  localparam logic [2:0] CTRL_HU   = 3'b101;
  localparam logic [2:0] CTRL_WU   = 3'b110;
  localparam logic [2:0] CTRL_D    = 3'b111;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  function automatic logic [3:0] ctrl_size(input logic [2:0] ctrl);
    case (ctrl)
      CTRL_B, CTRL_BU:  return 4'd1;
      CTRL_H, CTRL_HU:  return 4'd2;
      CTRL_W, CTRL_WU:  return 4'd4;
      CTRL_D:           return 4'd8;
      default:          return 4'd0;
    endcase
  endfunction

  function automatic logic ctrl_signed(input logic [2:0] ctrl);
    return (ctrl == CTRL_B) || (ctrl == CTRL_H) || (ctrl == CTRL_W) || (ctrl == CTRL_D);
  endfunction

endpackage

// File: rtl/mem_lane_extender.sv
// mem_lane_extender: combinational load-data aligner.
// Shifts the merged beat lanes right by off bytes, keeps size bytes and
// fills the rest with the access's sign bit (sext=1) or zeros.
// Ports:
//   merged [2*XLEN] : {beat1 lanes, beat0 lanes}
//   off             : byte offset of the access within the bus word
//   size            : access size in bytes (1/2/4/8)
//   sext            : 1 = sign-extend, 0 = zero-extend
//   data   [XLEN]   : extended result
module mem_lane_extender #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]         merged,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [3:0]                size,
  input  logic                      sext,
  output logic [XLEN-1:0]           data
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] shifted;
  logic            fill;

  always_comb begin
    shifted = XLEN'(merged >> {off, 3'b000});
    fill    = 1'b0;
    data    = '0;
    for (int i = 0; i < NB; i++) begin
      if (sext && (i == int'(size) - 1)) fill = shifted[i*8+7];
    end
    for (int i = 0; i < NB; i++) begin
      data[i*8 +: 8] = (i < int'(size)) ? shifted[i*8 +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: handshaked load/store unit between the memory stage and
// the data-memory bus. One request at a time; byte-granular accesses become
// aligned bus beats with byte enables; load data is sign/zero-extended.
// Build option: MEM_MISALIGNED_SPLIT_EN -- when defined, word-crossing
// accesses are split into two beats; when undefined, any access whose offset
// is not a multiple of its size faults without touching the bus.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready, req_addr, req_we, req_ctrl, req_wdata : request
//   resp_valid, resp_rdata, resp_fault                          : completion
//   bus_valid/bus_ready, bus_addr, bus_we, bus_be, bus_wdata,
//   bus_rdata                                                   : memory bus
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [2:0]          req_ctrl,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_fault,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [XLEN/8-1:0]   bus_be,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic [XLEN-1:0]     bus_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  // Rotating by the byte offset places each store byte on its lane; bytes
  // that wrap past the top lane land on the low lanes used by BEAT1.
  function automatic logic [XLEN-1:0] lane_rotate(input logic [XLEN-1:0] d,
                                                  input logic [OFF_W-1:0] o);
    logic [2*XLEN-1:0] t;
    t = {d, d} << {o, 3'b000};
    return t[2*XLEN-1:XLEN];
  endfunction

  state_t state, state_nx;

  logic [ADDR_W-1:0] waddr_q;
  logic [OFF_W-1:0]  off_q;
  logic [3:0]        size_q;
  logic              we_q;
  logic              sext_q;
  logic [XLEN-1:0]   wdata_q;

  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_size;
  logic              req_fault;

  logic [15:0]       mask;
  logic [NB-1:0]     be0;
  logic              crossing;
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   ext_data;
  logic              load_done;

  assign req_off  = req_addr[OFF_W-1:0];
  assign req_size = ctrl_size(req_ctrl);

  always_comb begin
    req_fault = 1'b0;
    if ((XLEN == 32) && (req_ctrl == CTRL_WU || req_ctrl == CTRL_D)) req_fault = 1'b1;
    if (req_we && (req_ctrl == CTRL_BU || req_ctrl == CTRL_HU || req_ctrl == CTRL_WU))
      req_fault = 1'b1;
`ifndef MEM_MISALIGNED_SPLIT_EN
    if ((req_size != 4'd0) && ((req_off & OFF_W'(req_size - 4'd1)) != '0)) req_fault = 1'b1;
`endif
  end

  // Byte-enable mask of the whole access before it is split across beats.
  assign mask = (16'd1 << size_q) - 16'd1;

`ifdef MEM_MISALIGNED_SPLIT_EN
  logic [2*NB-1:0] be_full;
  logic [NB-1:0]   be1;
  logic [XLEN-1:0] rdata0_q;

  assign be_full  = (2*NB)'(mask) << off_q;
  assign be0      = be_full[NB-1:0];
  assign be1      = be_full[2*NB-1:NB];
  assign crossing = |be1;
  assign merged   = (state == BEAT1) ? {bus_rdata, rdata0_q} : {{XLEN{1'b0}}, bus_rdata};

  always_ff @(posedge clk) begin
    if (state == BEAT0 && bus_ready) rdata0_q <= bus_rdata;
  end
`else
  assign be0      = NB'(mask) << off_q;
  assign crossing = 1'b0;
  assign merged   = {{XLEN{1'b0}}, bus_rdata};
`endif

  mem_lane_extender #(.XLEN(XLEN)) u_ext (
    .merged (merged),
    .off    (off_q),
    .size   (size_q),
    .sext   (sext_q),
    .data   (ext_data)
  );

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    bus_valid  = 1'b0;
    bus_we     = 1'b0;
    bus_be     = '0;
    bus_addr   = '0;
    bus_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = (req_fault || req_ctrl == CTRL_NONE) ? RESP : BEAT0;
      end
      BEAT0: begin
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_be    = be0;
        bus_addr  = waddr_q;
        bus_wdata = wdata_q;
        if (bus_ready) state_nx = crossing ? BEAT1 : RESP;
      end
`ifdef MEM_MISALIGNED_SPLIT_EN
      BEAT1: begin
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_be    = be1;
        bus_addr  = waddr_q + ADDR_W'(NB);
        bus_wdata = wdata_q;
        if (bus_ready) state_nx = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign load_done = bus_valid && bus_ready && (state_nx == RESP) && !we_q;

  // Control and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        resp_rdata <= '0;
        resp_fault <= req_fault;
      end else if (load_done) begin
        resp_rdata <= ext_data;
      end
    end
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      waddr_q <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      off_q   <= req_off;
      size_q  <= req_size;
      we_q    <= req_we;
      sext_q  <= ctrl_signed(req_ctrl);
      wdata_q <= lane_rotate(req_wdata, req_off);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;

  // XLEN=32 instance
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_ctrl;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  // XLEN=64 instance
  logic        q_req_valid, q_req_ready, q_req_we;
  logic [31:0] q_req_addr;
  logic [63:0] q_req_wdata;
  logic [2:0]  q_req_ctrl;
  logic        q_resp_valid, q_resp_fault;
  logic [63:0] q_resp_rdata;
  logic        q_bus_valid, q_bus_ready, q_bus_we;
  logic [31:0] q_bus_addr;
  logic [63:0] q_bus_wdata, q_bus_rdata;
  logic [7:0]  q_bus_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_ctrl(req_ctrl), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  mem_access_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(q_req_valid), .req_ready(q_req_ready), .req_addr(q_req_addr),
    .req_we(q_req_we), .req_ctrl(q_req_ctrl), .req_wdata(q_req_wdata),
    .resp_valid(q_resp_valid), .resp_rdata(q_resp_rdata), .resp_fault(q_resp_fault),
    .bus_valid(q_bus_valid), .bus_ready(q_bus_ready), .bus_addr(q_bus_addr),
    .bus_we(q_bus_we), .bus_be(q_bus_be), .bus_wdata(q_bus_wdata), .bus_rdata(q_bus_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request to the 32-bit unit for one cycle; returns in cycle N+1.
  task automatic issue(input logic [31:0] a, input logic we, input logic [2:0] c,
                       input logic [31:0] wd);
    req_addr = a; req_we = we; req_ctrl = c; req_wdata = wd; req_valid = 1'b1;
    chk("req_ready_before_issue", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_ctrl = 0; req_wdata = 0;
    bus_ready = 0; bus_rdata = 0;
    q_req_valid = 0; q_req_we = 0; q_req_addr = 0; q_req_ctrl = 0; q_req_wdata = 0;
    q_bus_ready = 0; q_bus_rdata = 0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // lb at 0x1003, negative byte
    issue(32'h1003, 0, 3'b001, 0);
    chk("lb_bus_valid", bus_valid, 1);
    chk("lb_bus_addr", bus_addr, 32'h1000);
    chk("lb_bus_be", bus_be, 4'b1000);
    chk("lb_bus_we", bus_we, 0);
    chk("lb_no_resp_yet", resp_valid, 0);
    bus_rdata = 32'h8012_3456; bus_ready = 1;
    tick();
    bus_ready = 0;
    chk("lb_resp_valid", resp_valid, 1);
    chk("lb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_resp_fault", resp_fault, 0);
    chk("lb_bus_idle", bus_valid, 0);
    tick();
    chk("lb_resp_pulse", resp_valid, 0);

    // lhu at 0x1002
    issue(32'h1002, 0, 3'b101, 0);
    chk("lhu_bus_be", bus_be, 4'b1100);
    bus_rdata = 32'hBEEF_0000; bus_ready = 1;
    tick();
    bus_ready = 0;
    chk("lhu_resp_valid", resp_valid, 1);
    chk("lhu_resp_rdata", resp_rdata, 32'h0000_BEEF);
    tick();

    // sw 0x11223344 at 0x1003 (word-crossing)
    issue(32'h1003, 1, 3'b011, 32'h1122_3344);
`ifdef MEM_MISALIGNED_SPLIT_EN
    chk("sw_b0_valid", bus_valid, 1);
    chk("sw_b0_addr", bus_addr, 32'h1000);
    chk("sw_b0_be", bus_be, 4'b1000);
    chk("sw_b0_we", bus_we, 1);
    chk("sw_b0_data", bus_wdata[31:24], 8'h44);
    bus_ready = 1;
    tick();
    chk("sw_b1_valid", bus_valid, 1);
    chk("sw_b1_addr", bus_addr, 32'h1004);
    chk("sw_b1_be", bus_be, 4'b0111);
    chk("sw_b1_data", bus_wdata[23:0], 24'h112233);
    chk("sw_b1_no_resp", resp_valid, 0);
    tick();
    bus_ready = 0;
    chk("sw_resp_valid", resp_valid, 1);
    chk("sw_resp_fault", resp_fault, 0);
    chk("sw_resp_rdata", resp_rdata, 0);
`else
    chk("sw_fault_valid", resp_valid, 1);
    chk("sw_fault_flag", resp_fault, 1);
    chk("sw_fault_no_bus", bus_valid, 0);
`endif
    tick();

    // lw at 0x1002 (crossing) with merge
    issue(32'h1002, 0, 3'b011, 0);
`ifdef MEM_MISALIGNED_SPLIT_EN
    chk("lwx_b0_be", bus_be, 4'b1100);
    bus_rdata = 32'hBBAA_0000; bus_ready = 1;
    tick();
    chk("lwx_b1_addr", bus_addr, 32'h1004);
    chk("lwx_b1_be", bus_be, 4'b0011);
    bus_rdata = 32'h0000_DDCC;
    tick();
    bus_ready = 0;
    chk("lwx_resp_valid", resp_valid, 1);
    chk("lwx_resp_rdata", resp_rdata, 32'hDDCC_BBAA);
`else
    chk("lwx_fault_valid", resp_valid, 1);
    chk("lwx_fault_flag", resp_fault, 1);
    chk("lwx_no_bus", bus_valid, 0);
`endif
    tick();

    // lh at 0xFFFFFFFF: second beat wraps to address 0
    issue(32'hFFFF_FFFF, 0, 3'b010, 0);
`ifdef MEM_MISALIGNED_SPLIT_EN
    chk("lhw_b0_addr", bus_addr, 32'hFFFF_FFFC);
    chk("lhw_b0_be", bus_be, 4'b1000);
    bus_rdata = 32'h3400_0000; bus_ready = 1;
    tick();
    chk("lhw_b1_addr", bus_addr, 32'h0000_0000);
    chk("lhw_b1_be", bus_be, 4'b0001);
    bus_rdata = 32'h0000_0012;
    tick();
    bus_ready = 0;
    chk("lhw_resp_rdata", resp_rdata, 32'h0000_1234);
`else
    chk("lhw_fault_flag", resp_fault, 1);
    chk("lhw_no_bus", bus_valid, 0);
`endif
    tick();

    // ctrl 111 illegal at XLEN=32
    issue(32'h2000, 0, 3'b111, 0);
    chk("d32_resp_valid", resp_valid, 1);
    chk("d32_fault", resp_fault, 1);
    chk("d32_no_bus", bus_valid, 0);
    tick();

    // ctrl none: response without fault, no bus
    issue(32'h2000, 0, 3'b000, 0);
    chk("none_resp_valid", resp_valid, 1);
    chk("none_fault", resp_fault, 0);
    chk("none_rdata", resp_rdata, 0);
    chk("none_no_bus", bus_valid, 0);
    tick();

    // sb 0xA5 at 0x1001 with one wait cycle
    issue(32'h1001, 1, 3'b001, 32'h0000_00A5);
    chk("sb_be", bus_be, 4'b0010);
    chk("sb_data", bus_wdata[15:8], 8'hA5);
    tick();
    chk("sb_wait_valid", bus_valid, 1);
    chk("sb_wait_be", bus_be, 4'b0010);
    chk("sb_wait_no_resp", resp_valid, 0);
    bus_ready = 1;
    tick();
    bus_ready = 0;
    chk("sb_resp_valid", resp_valid, 1);
    chk("sb_resp_rdata", resp_rdata, 0);
    tick();

    // lw stalled 3 cycles, then reset during BEAT0
    issue(32'h3000, 0, 3'b011, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_bus_valid", bus_valid, 1);
      chk("stall_bus_addr", bus_addr, 32'h3000);
      chk("stall_bus_be", bus_be, 4'b1111);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rstmid_bus_valid", bus_valid, 0);
    chk("rstmid_resp_valid", resp_valid, 0);
    tick();
    rst = 1'b0;
    chk("rstmid_req_ready", req_ready, 1);
    chk("rstmid_no_resp", resp_valid, 0);
    tick();
    chk("rstmid_no_resp_later", resp_valid, 0);

    // XLEN=64: ld at 0x8
    q_req_addr = 32'h8; q_req_we = 0; q_req_ctrl = 3'b111; q_req_valid = 1;
    tick();
    q_req_valid = 0;
    chk("ld64_bus_addr", q_bus_addr, 32'h8);
    chk("ld64_bus_be", q_bus_be, 8'hFF);
    q_bus_rdata = 64'h8000_0000_0000_0001; q_bus_ready = 1;
    tick();
    q_bus_ready = 0;
    chk("ld64_resp_valid", q_resp_valid, 1);
    chk("ld64_resp_rdata", q_resp_rdata, 64'h8000_0000_0000_0001);
    tick();

    // XLEN=64: lwu at 0xC
    q_req_addr = 32'hC; q_req_ctrl = 3'b110; q_req_valid = 1;
    tick();
    q_req_valid = 0;
    chk("lwu64_bus_addr", q_bus_addr, 32'h8);
    chk("lwu64_bus_be", q_bus_be, 8'hF0);
    q_bus_rdata = 64'h89AB_CDEF_0000_0000; q_bus_ready = 1;
    tick();
    q_bus_ready = 0;
    chk("lwu64_resp_rdata", q_resp_rdata, 64'h0000_0000_89AB_CDEF);
    chk("lwu64_fault", q_resp_fault, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
